hex_output_port: RTL and testbench

- Output-direction peripheral port: the computer writes 16-bit words over the port bus (data/DE/DRW), and the port shows them on four seven-segment digits and the red LEDs.
- Writes are buffered in a small FIFO. A pacing state machine holds each word on the display for HOLD_CYCLES clocks before showing the next, so bursts from the CPU are all visible.
- The port also returns the currently displayed word on a read strobe.
- Sits on the same port bus as the switch input port, at the opposite end of the transfer direction.

---
 rtl/hex_output_port_pkg.sv | 32 +++
 rtl/hex_output_port_if.sv | 23 ++
 rtl/hex_output_port_hex_to_7seg.sv | 12 +
 rtl/hex_output_port.sv | 110 +++++++++++
 tb/tb_hex_output_port.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hex_output_port_pkg.sv
// Shared definitions for the hex output port: bus width, pacing FSM state
// encoding and the active-low seven-segment glyph table.
`timescale 1ns/1ps
package hex_output_port_pkg;

    localparam int BUS_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Segment order {g,f,e,d,c,b,a}, active-low. Index 15 is leftmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_output_port_if.sv
// Port bus between the CPU (master) and the hex output port (slave).
`timescale 1ns/1ps
interface hex_output_port_if;
    import hex_output_port_pkg::*;

    logic [BUS_W-1:0] data;
    logic             DE;
    logic             DRW;
    logic [BUS_W-1:0] rd_data;
    logic             ack;
    logic             full;

    modport master (
        output data, DE, DRW,
        input  rd_data, ack, full
    );

    modport slave (
        input  data, DE, DRW,
        output rd_data, ack, full
    );

endinterface

// File: rtl/hex_output_port_hex_to_7seg.sv
// One hex nibble to an active-low seven-segment pattern.
`timescale 1ns/1ps
module hex_to_7seg
    import hex_output_port_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/hex_output_port.sv
// Output port: buffers CPU writes in a FIFO and paces them onto four hex
// digits and the red LEDs, holding each word for HOLD_CYCLES clocks.
// DEPTH must be a power of two (>= 2); HOLD_CYCLES must be >= 1.
`timescale 1ns/1ps
module hex_output_port
    import hex_output_port_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    hex_output_port_if.slave     bus,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [9:0]           LEDR
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

    logic [BUS_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              ack_q;
    logic [1:0]        state_q, state_d;
    logic [HCNT_W-1:0] hold_q, hold_d;
    logic [BUS_W-1:0]  disp_q, disp_d;
    logic              push;
    logic              pop;

    // full is the registered flag, so a push during a popping LOAD cycle
    // with a full FIFO is still refused.
    assign push = bus.DE && bus.DRW && !full_q;
    // LOAD is only entered with a non-empty FIFO, so it always pops.
    assign pop  = (state_q == ST_LOAD);

    // FIFO bookkeeping and display register next state
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        disp_d   = pop ? mem_q[rd_ptr_q] : disp_q;
    end

    // Pacing FSM: IDLE waits for data, LOAD pops one word, HOLD keeps it up
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                hold_d = hold_q + HCNT_W'(1);
                if (hold_q == HCNT_W'(HOLD_CYCLES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= bus.data;
    end

    // Control and display state with asynchronous reset
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ack_q    <= 1'b0;
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            disp_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ack_q    <= push;
            state_q  <= state_d;
            hold_q   <= hold_d;
            disp_q   <= disp_d;
        end
    end

    assign bus.rd_data = disp_q;
    assign bus.ack     = ack_q;
    assign bus.full    = full_q;
    assign LEDR        = disp_q[9:0];

    hex_to_7seg u_hex0 (.nib_i(disp_q[3:0]),   .seg_o(HEX0));
    hex_to_7seg u_hex1 (.nib_i(disp_q[7:4]),   .seg_o(HEX1));
    hex_to_7seg u_hex2 (.nib_i(disp_q[11:8]),  .seg_o(HEX2));
    hex_to_7seg u_hex3 (.nib_i(disp_q[15:12]), .seg_o(HEX3));

endmodule

// File: tb/tb_hex_output_port.sv
// Directed bench for hex_output_port with DEPTH = 4, HOLD_CYCLES = 4.
`timescale 1ns/1ps
module tb_hex_output_port;

    localparam logic [6:0] SEG0 = 7'b1000000;

    logic       clk;
    logic       reset_n;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [9:0] ledr;
    int         n_assert;
    int         n_fail;

    hex_output_port_if bus ();

    hex_output_port #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .LEDR     (ledr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] d);
        bus.data = d;
        bus.DE   = 1'b1;
        bus.DRW  = 1'b1;
        tick();
        bus.DE   = 1'b0;
        bus.DRW  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hex0"}, {9'd0, hex0}, {9'd0, SEG0});
        chk({tag, "_hex1"}, {9'd0, hex1}, {9'd0, SEG0});
        chk({tag, "_hex2"}, {9'd0, hex2}, {9'd0, SEG0});
        chk({tag, "_hex3"}, {9'd0, hex3}, {9'd0, SEG0});
        chk({tag, "_ledr"}, {6'd0, ledr}, 16'h0000);
        chk({tag, "_ack"},  {15'd0, bus.ack},  16'h0000);
        chk({tag, "_full"}, {15'd0, bus.full}, 16'h0000);
        chk({tag, "_rd"},   bus.rd_data, 16'h0000);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.data = '0;
        bus.DE   = 1'b0;
        bus.DRW  = 1'b0;

        // Reset and idle
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk_reset_outputs("reset");

        // Single write 12AF at edge n
        wr(16'h12AF);
        chk("single_ack_n1", {15'd0, bus.ack}, 16'h0001);
        chk("single_disp_n", bus.rd_data, 16'h0000);
        tick();
        chk("single_ack_n2", {15'd0, bus.ack}, 16'h0000);
        chk("single_disp_n1", bus.rd_data, 16'h0000);
        tick();
        chk("single_disp_n2", bus.rd_data, 16'h12AF);
        chk("single_hex3", {9'd0, hex3}, {9'd0, 7'b1111001});
        chk("single_hex2", {9'd0, hex2}, {9'd0, 7'b0100100});
        chk("single_hex1", {9'd0, hex1}, {9'd0, 7'b0001000});
        chk("single_hex0", {9'd0, hex0}, {9'd0, 7'b0001110});
        chk("single_ledr", {6'd0, ledr}, 16'h02AF);

        // Burst of five while 12AF is still held: four accepted, fifth dropped
        for (int w = 1; w <= 4; w++) begin
            wr(16'(w));
            chk("burst_ack", {15'd0, bus.ack}, 16'h0001);
            chk("burst_full", {15'd0, bus.full}, (w == 4) ? 16'h0001 : 16'h0000);
        end
        wr(16'h0005);
        chk("burst_drop_ack", {15'd0, bus.ack}, 16'h0000);
        chk("burst_drop_full", {15'd0, bus.full}, 16'h0001);
        chk("burst_drop_disp", bus.rd_data, 16'h12AF);
        tick();
        chk("burst_disp_1", bus.rd_data, 16'h0001);
        chk("burst_full_after_pop", {15'd0, bus.full}, 16'h0000);
        for (int w = 2; w <= 4; w++) begin
            repeat (5) tick();
            chk("burst_hold", bus.rd_data, 16'(w - 1));
            tick();
            chk("burst_step", bus.rd_data, 16'(w));
        end
        repeat (20) tick();
        chk("burst_final_hold", bus.rd_data, 16'h0004);
        chk("burst_final_hex0", {9'd0, hex0}, {9'd0, 7'b0011001});
        chk("burst_final_full", {15'd0, bus.full}, 16'h0000);

        // Fill FIFO during HOLD of A000, then write during the popping LOAD cycle
        wr(16'hA000);
        tick();
        tick();
        chk("fill_disp_a000", bus.rd_data, 16'hA000);
        wr(16'hBEEF);
        chk("fill_ack1", {15'd0, bus.ack}, 16'h0001);
        wr(16'hB002);
        wr(16'hB003);
        wr(16'hB004);
        chk("fill_ack4", {15'd0, bus.ack}, 16'h0001);
        chk("fill_full", {15'd0, bus.full}, 16'h0001);
        tick();
        chk("fill_disp_still", bus.rd_data, 16'hA000);
        wr(16'hC0DE);
        chk("loadpop_reject_ack", {15'd0, bus.ack}, 16'h0000);
        chk("loadpop_full_clear", {15'd0, bus.full}, 16'h0000);
        chk("loadpop_disp", bus.rd_data, 16'hBEEF);
        wr(16'hC0DE);
        chk("retry_ack", {15'd0, bus.ack}, 16'h0001);
        chk("retry_full", {15'd0, bus.full}, 16'h0001);

        // Read strobe while BEEF is displayed
        bus.DE  = 1'b1;
        bus.DRW = 1'b0;
        tick();
        bus.DE  = 1'b0;
        chk("read_rd", bus.rd_data, 16'hBEEF);
        chk("read_ack", {15'd0, bus.ack}, 16'h0000);
        chk("read_full", {15'd0, bus.full}, 16'h0001);
        repeat (4) tick();
        chk("next_disp_b002", bus.rd_data, 16'hB002);
        chk("next_full", {15'd0, bus.full}, 16'h0000);

        // Asynchronous reset mid-HOLD with three words queued
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick();
        tick();
        reset_n = 1'b1;
        repeat (40) begin
            tick();
            chk("post_reset_disp", bus.rd_data, 16'h0000);
        end
        chk("post_reset_full", {15'd0, bus.full}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
